rgb_color_sequencer: RTL and testbench
======================================

Name: rgb_color_sequencer

Overview:
- Upstream stage of the RGB LED decoder: converts raw push-button activity into the 3-bit colour code the decoder consumes.
- Codes 0..6 select the seven lit colours; code 7 is "off", which the decoder drives to all-zero.
- Contains button synchronisers, debouncers, a power/run FSM, a wrap-around colour counter and an optional auto-cycle timer.

Parameters:
- DEBOUNCE_CYCLES, 20000, consecutive cycles a synchronised button must disagree with its debounced level before that level flips; min 1.
- CNT_W, 15, width of each debounce counter; must hold DEBOUNCE_CYCLES-1.
- AUTO_PERIOD, 50000000, cycles between automatic colour advances; min 2.
- AUTO_W, 26, width of the auto-cycle timer; must hold AUTO_PERIOD-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn_pwr  input  1  raw button, active-high, asynchronous to clk; toggles OFF/RUN.
- btn_next  input  1  raw button, active-high; advances to the next colour.
- btn_prev  input  1  raw button, active-high; steps back to the previous colour.
- auto_en  input  1  level input; enables auto-cycling in RUN. Present only with the optional feature.
- color_code  output  3  code fed to the decoder's 3-bit input.
- changed  output  1  one-cycle pulse in the cycle color_code takes a new value.
- running  output  1  high while the FSM is in RUN.

Behaviour:
- Reset (rst=0, asynchronous): FSM=OFF, color_code=7, saved colour=0, changed=0, running=0; synchronisers, debounced levels, debounce counters, press pulses and timer all cleared. Reset asserted mid-debounce or mid-period discards all partial progress.
- Each button passes through a 2-flop synchroniser.
- Debounce: if the synchronised value equals the debounced level, the counter is 0. Otherwise the counter increments; in the cycle it reaches DEBOUNCE_CYCLES-1 while the values still differ, the debounced level flips on the next edge and the counter clears. A glitch shorter than DEBOUNCE_CYCLES cycles produces no flip.
- A 0->1 flip of a debounced level produces a registered one-cycle press pulse. A 1->0 flip produces nothing. Holding a button gives exactly one press.
- Latency: with the raw button stable high, color_code updates exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it high.
- FSM OFF: color_code=7, running=0. A pwr press moves to RUN and color_code loads the saved colour. next/prev presses are ignored.
- FSM RUN: running=1.
  - pwr press: the saved colour is set to the current code, then the FSM moves to OFF with color_code=7.
  - next press: code+1, wrapping 6->0.
  - prev press: code-1, wrapping 0->6.
- Simultaneous presses in one cycle:
  - pwr with anything: pwr wins and the others are dropped.
  - next with prev: no change, no changed pulse.
- changed pulses on every color_code update, including the OFF<->RUN transitions. It never pulses when the code is unchanged.
- color_code is always in 0..6 in RUN and always 7 in OFF.

Optional Feature:
- Macro: RGB_SEQ_AUTO_CYCLE_EN.
- Defined:
  - The auto_en port exists and an AUTO_W-bit timer runs while in RUN with auto_en=1.
  - When the timer reaches AUTO_PERIOD-1, it wraps to 0 and the colour advances as if next were pressed.
  - Any next/prev press clears the timer. A manual press coinciding with an auto advance wins: the manual action applies once and the timer clears.
  - The timer clears and holds at 0 in OFF or when auto_en=0.
- Undefined: there is no auto_en port, no timer and no auto advance; the block is purely button-driven.

Test Plan:
- DEBOUNCE_CYCLES=4. Release rst, hold btn_pwr high for 10 cycles -> color_code goes 7->0 exactly 7 edges after first sample, changed pulses once, running=1.
- In RUN at code 6, press btn_next -> code 0. Then press btn_prev twice -> codes 6, then 5. Exactly one changed pulse per press.
- Apply a 3-cycle btn_next glitch -> no code change and no changed pulse. A 4-cycle-or-longer pulse -> exactly one advance.
- At code 3, btn_next and btn_prev rise on the same cycle for 8 cycles -> code stays 3, changed stays 0. Then btn_pwr with btn_next -> OFF, code 7. Next pwr press -> code 3.
- With RGB_SEQ_AUTO_CYCLE_EN, AUTO_PERIOD=10, auto_en=1 in RUN at 0 -> code advances every 10 cycles 0,1,...,6,0. A btn_next press resets the spacing to 10 cycles after the press. auto_en=0 -> code frozen.
- Assert rst mid-debounce and in RUN at code 5 -> immediately code 7, running 0, changed 0. After release, the first pwr press restores code 0.

Source files
------------

// File: rtl/rgb_color_sequencer.sv
// -----------------------------------------------------------------------------
// rgb_color_sequencer
//
// Purpose:
//   Upstream stage of the RGB LED decoder. Turns raw push-button activity into
//   the 3-bit colour code the decoder consumes. Codes 0..6 are the seven lit
//   colours; code 7 means "off".
//
//   Datapath per button: 2-flop synchroniser -> debouncer -> registered
//   one-cycle press pulse on a debounced 0->1 flip. A two-state power/run FSM
//   consumes the press pulses and owns color_code.
//
// Optional feature (macro RGB_SEQ_AUTO_CYCLE_EN):
//   When defined, an auto_en input appears. An AUTO_W-bit timer then runs
//   while in RUN with auto_en=1 and advances the colour every AUTO_PERIOD
//   cycles as if next were pressed. When undefined, the block is purely
//   button-driven.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles before a debounced flip (>=1)
//   CNT_W            debounce counter width, must hold DEBOUNCE_CYCLES-1
//   AUTO_PERIOD      cycles between automatic advances (>=2)
//   AUTO_W           auto timer width, must hold AUTO_PERIOD-1
//
// Ports:
//   clk         system clock, rising-edge
//   rst         asynchronous active-low reset
//   btn_pwr     raw button, active-high: toggles OFF/RUN
//   btn_next    raw button, active-high: next colour (6 wraps to 0)
//   btn_prev    raw button, active-high: previous colour (0 wraps to 6)
//   auto_en     level enable for auto-cycling (only with RGB_SEQ_AUTO_CYCLE_EN)
//   color_code  3-bit code to the decoder (7 in OFF, 0..6 in RUN)
//   changed     one-cycle pulse in the cycle color_code takes a new value
//   running     high while the FSM is in RUN
//   state_dbg   FSM state for observation (0 = OFF, 1 = RUN)
//
// Latency: with a raw button held high, color_code moves exactly
// DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it high
// (2 synchroniser edges, DEBOUNCE_CYCLES edges to flip and emit the press,
// 1 edge for the FSM).
// -----------------------------------------------------------------------------
module rgb_color_sequencer #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 15,
  parameter int AUTO_PERIOD     = 50000000,
  parameter int AUTO_W          = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pwr,
  input  logic       btn_next,
  input  logic       btn_prev,
`ifdef RGB_SEQ_AUTO_CYCLE_EN
  input  logic       auto_en,
`endif
  output logic [2:0] color_code,
  output logic       changed,
  output logic       running,
  output logic       state_dbg
);

  // Button index map used by the synchroniser/debounce arrays.
  localparam int B_PWR  = 0;
  localparam int B_NEXT = 1;
  localparam int B_PREV = 2;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] CODE_OFF  = 3'd7;
  localparam logic [2:0] CODE_LAST = 3'd6;

  typedef enum logic {
    S_OFF = 1'b0,
    S_RUN = 1'b1
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Synchronisers and debouncers
  // ---------------------------------------------------------------------------
  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       deb;
  logic [2:0]       press;
  logic [CNT_W-1:0] db_cnt [3];

  assign raw = {btn_prev, btn_next, btn_pwr};

  // The counter only runs while the synchronised value disagrees with the
  // debounced level; any agreement (including a glitch ending) clears it, so
  // only DEBOUNCE_CYCLES consecutive disagreeing cycles cause a flip. The
  // press pulse is registered on the same edge as a 0->1 flip.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  logic press_pwr;
  logic press_next;
  logic press_prev;

  assign press_pwr  = press[B_PWR];
  assign press_next = press[B_NEXT];
  assign press_prev = press[B_PREV];

  // ---------------------------------------------------------------------------
  // Auto-cycle timer
  // ---------------------------------------------------------------------------
  logic auto_tick;

`ifdef RGB_SEQ_AUTO_CYCLE_EN
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);
  localparam logic [AUTO_W-1:0] AUTO_ONE  = AUTO_W'(1);

  logic [AUTO_W-1:0] auto_timer;

  assign auto_tick = (state == S_RUN) && auto_en && (auto_timer == AUTO_LAST);

  // Any button press restarts the spacing so the next automatic advance comes
  // a full period after the manual action. Outside RUN or with auto_en low the
  // timer is held at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      auto_timer <= '0;
    end else if ((state != S_RUN) || !auto_en ||
                 press_pwr || press_next || press_prev) begin
      auto_timer <= '0;
    end else if (auto_timer == AUTO_LAST) begin
      auto_timer <= '0;
    end else begin
      auto_timer <= auto_timer + AUTO_ONE;
    end
  end
`else
  assign auto_tick = 1'b0;

  // Timer parameters have no function in the button-only build.
  logic [AUTO_W-1:0] unused_auto_cfg;
  assign unused_auto_cfg = AUTO_W'(AUTO_PERIOD);
`endif

  // ---------------------------------------------------------------------------
  // Colour arithmetic (wraps within 0..6)
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] code_inc(input logic [2:0] c);
    return (c >= CODE_LAST) ? 3'd0 : c + 3'd1;
  endfunction

  function automatic logic [2:0] code_dec(input logic [2:0] c);
    return (c == 3'd0 || c > CODE_LAST) ? CODE_LAST : c - 3'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Power/run FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic [2:0] saved_code;

  // Priority in RUN: pwr over everything, then a lone next or prev, then the
  // auto tick. next together with prev cancels, and also suppresses an auto
  // tick landing in the same cycle (a manual action always wins).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_OFF;
      color_code <= CODE_OFF;
      saved_code <= 3'd0;
      changed    <= 1'b0;
      running    <= 1'b0;
    end else begin
      changed <= 1'b0;
      case (state)
        S_OFF: begin
          if (press_pwr) begin
            state      <= S_RUN;
            running    <= 1'b1;
            color_code <= saved_code;
            changed    <= 1'b1;
          end
        end
        S_RUN: begin
          if (press_pwr) begin
            state      <= S_OFF;
            running    <= 1'b0;
            saved_code <= color_code;
            color_code <= CODE_OFF;
            changed    <= 1'b1;
          end else if (press_next && !press_prev) begin
            color_code <= code_inc(color_code);
            changed    <= 1'b1;
          end else if (press_prev && !press_next) begin
            color_code <= code_dec(color_code);
            changed    <= 1'b1;
          end else if (!press_next && !press_prev && auto_tick) begin
            color_code <= code_inc(color_code);
            changed    <= 1'b1;
          end
        end
        default: begin
          state      <= S_OFF;
          running    <= 1'b0;
          color_code <= CODE_OFF;
        end
      endcase
    end
  end

  assign state_dbg = (state == S_RUN);

endmodule

// File: tb/tb_rgb_color_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rgb_color_sequencer
//
// Directed bench for rgb_color_sequencer with DEBOUNCE_CYCLES=4 and
// AUTO_PERIOD=10. Button presses are described in a table of
// {buttons, hold cycles, expected code, expected running, expected number of
// changed pulses}; latency, auto-cycling and reset are hand-written sequences.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_rgb_color_sequencer;

  localparam int DB   = 4;
  localparam int IDLE = 10;

  logic       clk;
  logic       rst;
  logic       btn_pwr;
  logic       btn_next;
  logic       btn_prev;
  logic       auto_en;
  logic [2:0] color_code;
  logic       changed;
  logic       running;
  logic       state_dbg;

  int n_checks;
  int n_err;
  int exp_cur;

  logic [2:0] exp_q [$];

  typedef struct {
    string name;
    logic  pwr;
    logic  nxt;
    logic  prv;
    int    hold;
    int    exp_code;
    int    exp_run;
    int    exp_chg;
  } vec_t;

  vec_t vq [$];

  // ---------------- clock/reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rgb_color_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (4),
    .AUTO_PERIOD    (10),
    .AUTO_W         (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_pwr   (btn_pwr),
    .btn_next  (btn_next),
    .btn_prev  (btn_prev),
`ifdef RGB_SEQ_AUTO_CYCLE_EN
    .auto_en   (auto_en),
`endif
    .color_code(color_code),
    .changed   (changed),
    .running   (running),
    .state_dbg (state_dbg)
  );

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(inout int nchg);
    @(posedge clk);
    #1;
    if (changed === 1'b1) nchg++;
  endtask

  task automatic press(input logic p, input logic n, input logic v,
                       input int hold, output int nchg);
    nchg     = 0;
    btn_pwr  = p;
    btn_next = n;
    btn_prev = v;
    for (int i = 0; i < hold; i++) step(nchg);
    btn_pwr  = 1'b0;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    for (int i = 0; i < IDLE; i++) step(nchg);
  endtask

  task automatic add_vec(input string name, input logic p, input logic n, input logic v,
                         input int hold, input int code, input int run, input int chg);
    vec_t r;
    r.name = name; r.pwr = p; r.nxt = n; r.prv = v; r.hold = hold;
    r.exp_code = code; r.exp_run = run; r.exp_chg = chg;
    vq.push_back(r);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nchg;
    logic [2:0] e;
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b0;
    btn_pwr  = 1'b0;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    auto_en  = 1'b0;

    add_vec("prev_0_to_6",     1'b0, 1'b0, 1'b1, 6,  6, 1, 1);
    add_vec("next_6_to_0",     1'b0, 1'b1, 1'b0, 6,  0, 1, 1);
    add_vec("prev_0_to_6b",    1'b0, 1'b0, 1'b1, 6,  6, 1, 1);
    add_vec("prev_6_to_5",     1'b0, 1'b0, 1'b1, 6,  5, 1, 1);
    add_vec("glitch_3cyc",     1'b0, 1'b1, 1'b0, 3,  5, 1, 0);
    add_vec("pulse_4cyc",      1'b0, 1'b1, 1'b0, 4,  6, 1, 1);
    add_vec("hold_one_press",  1'b0, 1'b1, 1'b0, 12, 0, 1, 1);
    add_vec("next_to_1",       1'b0, 1'b1, 1'b0, 5,  1, 1, 1);
    add_vec("next_to_2",       1'b0, 1'b1, 1'b0, 5,  2, 1, 1);
    add_vec("next_to_3",       1'b0, 1'b1, 1'b0, 5,  3, 1, 1);
    add_vec("next_prev_same",  1'b0, 1'b1, 1'b1, 8,  3, 1, 0);
    add_vec("pwr_with_next",   1'b1, 1'b1, 1'b0, 6,  7, 0, 1);
    add_vec("next_in_off",     1'b0, 1'b1, 1'b0, 6,  7, 0, 0);
    add_vec("prev_in_off",     1'b0, 1'b0, 1'b1, 6,  7, 0, 0);
    add_vec("pwr_restore_3",   1'b1, 1'b0, 1'b0, 6,  3, 1, 1);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_code",    32'(color_code), 7);
    check("reset_running", 32'(running),    0);
    check("reset_changed", 32'(changed),    0);
    check("reset_state",   32'(state_dbg),  0);

    // Power-on latency: first sampling edge is edge 1, code moves on edge DB+3.
    rst     = 1'b1;
    btn_pwr = 1'b1;
    for (int k = 1; k <= 10; k++) exp_q.push_back((k >= DB + 3) ? 3'd0 : 3'd7);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("latency_code_e%0d", k), 32'(color_code), 32'(e));
      check($sformatf("latency_chg_e%0d", k), 32'(changed), (k == DB + 3) ? 1 : 0);
    end
    btn_pwr = 1'b0;
    nchg = 0;
    for (int i = 0; i < IDLE; i++) step(nchg);
    check("poweron_running", 32'(running), 1);
    check("poweron_release_chg", 32'(nchg), 0);

    // Table-driven presses
    foreach (vq[i]) begin
      press(vq[i].pwr, vq[i].nxt, vq[i].prv, vq[i].hold, nchg);
      check({vq[i].name, "_code"}, 32'(color_code), vq[i].exp_code);
      check({vq[i].name, "_run"},  32'(running),    vq[i].exp_run);
      check({vq[i].name, "_chg"},  32'(nchg),       vq[i].exp_chg);
    end
    exp_cur = 3;

`ifdef RGB_SEQ_AUTO_CYCLE_EN
    // Auto-cycling from code 3 with a 10-cycle period.
    auto_en = 1'b1;
    nchg = 0;
    for (int k = 1; k <= 20; k++) begin
      step(nchg);
      if (k == 9)  check("auto_before_first", 32'(color_code), 3);
      if (k == 10) check("auto_first",        32'(color_code), 4);
      if (k == 19) check("auto_before_second", 32'(color_code), 4);
      if (k == 20) check("auto_second",       32'(color_code), 5);
    end
    check("auto_chg_count", 32'(nchg), 2);
    // Manual next restarts the spacing.
    nchg = 0;
    btn_next = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step(nchg);
      if (k == 6) btn_next = 1'b0;
      if (k == 6)  check("manual_before", 32'(color_code), 5);
      if (k == 7)  check("manual_applied", 32'(color_code), 6);
      if (k == 16) check("auto_respaced_before", 32'(color_code), 6);
      if (k == 17) check("auto_respaced", 32'(color_code), 0);
    end
    check("manual_auto_chg", 32'(nchg), 2);
    auto_en = 1'b0;
    nchg = 0;
    for (int k = 0; k < 30; k++) step(nchg);
    check("auto_off_frozen", 32'(color_code), 0);
    check("auto_off_chg",    32'(nchg), 0);
    exp_cur = 0;
`endif

    // Walk to code 5, then reset mid-debounce.
    for (int k = 0; k < (5 - exp_cur + 7) % 7; k++) press(1'b0, 1'b1, 1'b0, 5, nchg);
    check("walk_to_5", 32'(color_code), 5);
    btn_next = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_code",    32'(color_code), 7);
    check("async_rst_running", 32'(running),    0);
    check("async_rst_changed", 32'(changed),    0);
    btn_next = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    nchg = 0;
    for (int k = 0; k < 15; k++) step(nchg);
    check("post_rst_no_press", 32'(nchg), 0);
    check("post_rst_code",     32'(color_code), 7);
    press(1'b1, 1'b0, 1'b0, 6, nchg);
    check("post_rst_pwr_code", 32'(color_code), 0);
    check("post_rst_pwr_run",  32'(running),    1);
    check("post_rst_pwr_chg",  32'(nchg),       1);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
